// File: rtl/countdown_timer.sv
// Minutes:seconds countdown timer with an internal one-second prescaler,
// a load/start/pause/expiry FSM and a latched alarm output.
module countdown_timer #(
    parameter int CLK_DIV   = 100000000,
    parameter int DIV_WIDTH = 27,
    parameter int MAX_MIN   = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [6:0] min_in,
    input  logic [5:0] sec_in,
    input  logic       start,
    input  logic       stop,
    input  logic       ack,
    output logic [6:0] minutes,
    output logic [5:0] seconds,
    output logic       running,
    output logic       done,
    output logic       alarm
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [6:0]           MAX_MIN_V = 7'(MAX_MIN);
    localparam logic [DIV_WIDTH-1:0] TICK_AT   = DIV_WIDTH'(CLK_DIV - 1);

    state_t               state_q, state_d;
    logic [6:0]           min_q, min_d;
    logic [5:0]           sec_q, sec_d;
    logic [DIV_WIDTH-1:0] presc_q, presc_d;
    logic                 running_q, running_d;
    logic                 done_q, done_d;
    logic                 alarm_q, alarm_d;
    logic                 is_zero;

    function automatic logic [6:0] sat_min(input logic [6:0] v);
        return (v > MAX_MIN_V) ? MAX_MIN_V : v;
    endfunction

    function automatic logic [5:0] sat_sec(input logic [5:0] v);
        return (v > 6'd59) ? 6'd59 : v;
    endfunction

    assign is_zero = (min_q == 7'd0) && (sec_q == 6'd0);

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        presc_d = presc_q;
        alarm_d = alarm_q;
        done_d  = 1'b0;

        if (load) begin
            min_d   = sat_min(min_in);
            sec_d   = sat_sec(sec_in);
            presc_d = '0;
            state_d = IDLE;
            alarm_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, PAUSE: begin
                    if (!stop && start && !is_zero) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    // stop beats a coincident tick; the prescaler stays at
                    // TICK_AT so the pending tick fires right after resume
                    if (stop) begin
                        state_d = PAUSE;
                    end else if (presc_q == TICK_AT) begin
                        presc_d = '0;
                        if (sec_q != 6'd0) begin
                            sec_d = sec_q - 6'd1;
                            if (min_q == 7'd0 && sec_q == 6'd1) begin
                                state_d = DONE;
                                done_d  = 1'b1;
                                alarm_d = 1'b1;
                            end
                        end else begin
                            sec_d = 6'd59;
                            min_d = min_q - 7'd1;
                        end
                    end else begin
                        presc_d = presc_q + DIV_WIDTH'(1);
                    end
                end
                DONE: begin
                    if (ack) begin
                        state_d = IDLE;
                        alarm_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            min_q     <= '0;
            sec_q     <= '0;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            done_q    <= done_d;
            alarm_q   <= alarm_d;
        end
    end

    assign minutes = min_q;
    assign seconds = sec_q;
    assign running = running_q;
    assign done    = done_q;
    assign alarm   = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with CLK_DIV=4, MAX_MIN=99.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       reset, load, start, stop, ack;
    logic [6:0] min_in;
    logic [5:0] sec_in;
    logic [6:0] minutes;
    logic [5:0] seconds;
    logic       running, done, alarm;

    int n_checks = 0;
    int n_errors = 0;

    countdown_timer #(.CLK_DIV(4), .DIV_WIDTH(3), .MAX_MIN(99)) dut (
        .clk(clk), .reset(reset), .load(load), .min_in(min_in),
        .sec_in(sec_in), .start(start), .stop(stop), .ack(ack),
        .minutes(minutes), .seconds(seconds), .running(running),
        .done(done), .alarm(alarm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after a rising edge.
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int m, input int s);
        load = 1'b1; min_in = 7'(m); sec_in = 6'(s);
        cycles(1);
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; cycles(1); start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1; cycles(1); stop = 1'b0;
    endtask

    task automatic do_ack();
        ack = 1'b1; cycles(1); ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load = 0; start = 0; stop = 0; ack = 0;
        min_in = 0; sec_in = 0;
        cycles(2);
        reset = 1'b0;
        check("rst_min", minutes, 0);
        check("rst_sec", seconds, 0);
        check("rst_run", running, 0);
        check("rst_done", done, 0);
        check("rst_alarm", alarm, 0);

        // basic countdown to expiry
        do_load(0, 3);
        check("ld3_sec", seconds, 3);
        do_start();
        check("st_run", running, 1);
        cycles(3);
        check("pre_tick_sec", seconds, 3);
        cycles(1);
        check("tick1_sec", seconds, 2);
        cycles(4);
        check("tick2_sec", seconds, 1);
        cycles(3);
        check("pre_done", done, 0);
        cycles(1);
        check("exp_sec", seconds, 0);
        check("exp_min", minutes, 0);
        check("exp_done", done, 1);
        check("exp_alarm", alarm, 1);
        check("exp_run", running, 0);
        cycles(1);
        check("done_pulse_end", done, 0);
        check("alarm_hold", alarm, 1);
        check("no_wrap_sec", seconds, 0);

        // start ignored in DONE, ack clears, re-arm
        do_start();
        check("done_start_alarm", alarm, 1);
        check("done_start_run", running, 0);
        do_ack();
        check("ack_alarm", alarm, 0);
        do_load(0, 1);
        do_start();
        cycles(3);
        check("rearm_pre", done, 0);
        cycles(1);
        check("rearm_done", done, 1);

        // borrow
        do_load(1, 0);
        do_start();
        cycles(4);
        check("borrow_min", minutes, 0);
        check("borrow_sec", seconds, 59);
        do_load(10, 0);
        do_start();
        cycles(4);
        check("b10_min", minutes, 9);
        check("b10_sec", seconds, 59);

        // pause keeps the partial second
        do_load(0, 5);
        do_start();
        cycles(2);
        do_stop();
        check("pause_run", running, 0);
        cycles(10);
        check("pause_sec", seconds, 5);
        do_start();
        check("resume_run", running, 1);
        cycles(1);
        check("resume_sec1", seconds, 5);
        cycles(1);
        check("resume_sec2", seconds, 4);

        // stop coincident with tick
        do_load(0, 2);
        do_start();
        cycles(3);
        do_stop();
        check("stoptick_sec", seconds, 2);
        check("stoptick_run", running, 0);
        do_start();
        check("stoptick_res0", seconds, 2);
        cycles(1);
        check("stoptick_res1", seconds, 1);

        // saturation and zero start
        do_load(120, 63);
        check("sat_min", minutes, 99);
        check("sat_sec", seconds, 59);
        do_load(0, 0);
        do_start();
        check("zero_run", running, 0);
        cycles(5);
        check("zero_done", done, 0);
        check("zero_run2", running, 0);

        // load and start together: load wins
        load = 1'b1; start = 1'b1; min_in = 7'd0; sec_in = 6'd4;
        cycles(1);
        load = 1'b0; start = 1'b0;
        check("ldst_run", running, 0);
        check("ldst_sec", seconds, 4);

        // reset mid-count
        do_load(0, 3);
        do_start();
        cycles(4);
        check("mid_sec", seconds, 2);
        cycles(3);
        reset = 1'b1; cycles(1); reset = 1'b0;
        check("midrst_sec", seconds, 0);
        check("midrst_min", minutes, 0);
        check("midrst_run", running, 0);
        check("midrst_done", done, 0);

        // load during RUN restarts the prescaler
        do_load(0, 5);
        do_start();
        cycles(2);
        do_load(0, 7);
        check("ldrun_run", running, 0);
        check("ldrun_sec", seconds, 7);
        do_start();
        cycles(3);
        check("ldrun_pre", seconds, 7);
        cycles(1);
        check("ldrun_tick", seconds, 6);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
